hilo_div_unit: RTL and testbench
================================

# hilo_div_unit

Parametrised iterative integer divider producing the quotient and remainder that the execute stage writes into the HI/LO pair: LO takes the quotient and HI takes the remainder. The execute stage holds `start_i` high and stalls the pipeline until the result is ready. The block extends the execute-stage HI/LO move logic with multi-cycle DIV/DIVU support. It is generic in data width and in quotient bits retired per cycle.

## Interface
- `DATA_W`, 32: operand and result width. Must be even and ≥ 4.
- `BITS_PER_CYCLE`, 1: quotient bits retired per iteration cycle. Legal values are 1 and 2. `DATA_W % BITS_PER_CYCLE == 0`.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start_i`  in  1: divide request. Held high by the execute stage until `ready_o` is seen.
- `signed_i`  in  1: 1 = DIV (two's complement), 0 = DIVU.
- `dividend_i`  in  DATA_W: dividend. Sampled only on the accepting edge.
- `divisor_i`  in  DATA_W: divisor. Sampled only on the accepting edge.
- `annul_i`  in  1: flush/cancel (exception or branch squash).
- `stall_o`  out  1: combinational, `start_i && !ready_o && !annul_i`.
- `ready_o`  out  1: result valid, registered.
- `quotient_o`  out  DATA_W: result destined for LO, registered.
- `remainder_o`  out  DATA_W: result destined for HI, registered.
- `div_by_zero_o`  out  1: the divisor was zero, registered.

## Operation
- The controller has four states: IDLE, DIVZERO, ON and END.
- **IDLE**: when `start_i=1` and `annul_i=0`, the block latches the operands and `signed_i`.
  - If the divisor is 0, go to DIVZERO.
  - Otherwise go to ON with the iteration counter at 0.
- **Signed mode**: the operands are converted to absolute values on entry.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- **ON**: each edge performs `BITS_PER_CYCLE` restoring steps.
  - Each step does the partial-remainder shift, a trial subtraction of width DATA_W+1, and sets the quotient bit.
  - The counter increments by `BITS_PER_CYCLE`. When it reaches DATA_W, the sign fix-up is applied and the state goes to END.
- **DIVZERO**: the next edge goes to END with `quotient_o=0`, `remainder_o=0` and `div_by_zero_o=1`.
- **END**: `ready_o=1` and the results are held stable. Stay in END while `start_i=1`. When `start_i` drops, go to IDLE and clear `ready_o` and `div_by_zero_o`. The result registers keep their last values.
- **Overflow** (signed `-2^(DATA_W-1) / -1`): quotient = `-2^(DATA_W-1)` (wraps), remainder 0. No flag is raised.
- **Cancellation**:
  - `annul_i=1` in any state forces IDLE on the next edge, with `ready_o=0`. It has priority over `start_i`.
  - `start_i` dropping while in ON or DIVZERO also aborts to IDLE with no result.
- **Restart**: a new request from IDLE on the edge after an abort is legal. No stale partial state may leak into it.

## Timing
- **Reset values**: state IDLE, counter 0, `ready_o=0`, `quotient_o=0`, `remainder_o=0`, `div_by_zero_o=0`. `stall_o` then follows `start_i`.
- **Normal latency**: if edge 0 accepts the request, `ready_o` first rises after edge `DATA_W/BITS_PER_CYCLE + 1`.
  - DATA_W=32 with 1 bit/cycle: `ready_o` rises after edge 33.
  - DATA_W=32 with 2 bits/cycle: `ready_o` rises after edge 17.
- **Divide-by-zero latency**: `ready_o` rises after edge 2.
- **Stall release**: `stall_o` falls in the same cycle `ready_o` rises. The execute stage captures HI/LO that cycle, and `start_i` is low by the next edge.
- **Reset mid-operation**: the asynchronous clear takes effect immediately, with no result and no glitch on `ready_o` after release.
- **Back-to-back**: after END→IDLE, a new request may be accepted on the following edge. There is one idle bubble minimum.

## Structure
- Shared package `div_pkg`:
  - the state encoding (`DivFree`, `DivByZero`, `DivOn`, `DivEnd`);
  - the `DivStart`/`DivStop` and `DivResultReady`/`DivResultNotReady` constants.
- Sub-module `div_step`: one combinational restoring step of width DATA_W+1.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new partial remainder and quotient bit.
  - Instanced `BITS_PER_CYCLE` times in a chain.
- Top level holds the FSM, the counter, the operand/sign registers and the result registers.

## Test plan
- **Unsigned basic**: DATA_W=32, B=1, DIVU 100/7 → quotient 14, remainder 2, `ready_o` after edge 33, `stall_o` high for 33 cycles.
- **Signed rounding**: DIV −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/−2 → 0xFFFFFFFD, 1.
- **Signed overflow and zero divisor**:
  - DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0, `div_by_zero_o=0`.
  - DIVU 5/0 → `div_by_zero_o=1`, results 0, `ready_o` after edge 2.
- **Cancellation**:
  - `annul_i` pulsed at cycle 10 of a divide → IDLE, `ready_o` never rises. An immediate new 1000/10 then gives quotient 100, remainder 0 at the normal latency.
  - `start_i` dropped at cycle 5 → same abort behaviour.
- **BITS_PER_CYCLE=2**: 0xFFFFFFFF/3 unsigned → quotient 0x55555555, remainder 0, `ready_o` after edge 17. Random unsigned/signed sweep against a reference model.
- **Reset mid-operation**: `rst` asserted asynchronously mid-ON → all outputs read 0 immediately. After release, the first request completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide unit.
//   div_state_e       : controller state encoding
//   DivStart/DivStop  : levels of the execute-stage divide request
//   DivResultReady/DivResultNotReady : levels of the result-valid flag
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_i     : partial remainder entering the step (always < divisor)
//   divisor_i : divisor magnitude
//   bit_i     : next dividend bit shifted into the partial remainder
//   rem_o     : partial remainder after the step
//   q_o       : quotient bit retired by the step
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    logic [DATA_W-1:0] shifted_lo;
    logic [DATA_W-1:0] diff;

    // The shifted remainder is DATA_W+1 bits wide; the trial subtraction
    // succeeds (no borrow) exactly when it is >= divisor.
    assign q_o        = ({rem_i, bit_i} >= {1'b0, divisor_i});
    assign shifted_lo = {rem_i[DATA_W-2:0], bit_i};
    // On success the true difference is < divisor, so modular DATA_W-bit
    // subtraction on the low bits gives it exactly.
    assign diff       = shifted_lo - divisor_i;
    assign rem_o      = q_o ? diff : shifted_lo;

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative DIV/DIVU unit feeding the execute-stage HI/LO pair.
// LO receives quotient_o, HI receives remainder_o.
//   clk, rst       : clock, asynchronous active-high reset
//   start_i        : request, held high until ready_o is seen
//   signed_i       : 1 = DIV (two's complement), 0 = DIVU
//   dividend_i     : dividend, sampled on the accepting edge
//   divisor_i      : divisor, sampled on the accepting edge
//   annul_i        : flush/cancel, overrides start_i
//   stall_o        : combinational pipeline stall request
//   ready_o        : registered result-valid
//   quotient_o     : registered quotient
//   remainder_o    : registered remainder
//   div_by_zero_o  : registered zero-divisor flag
module hilo_div_unit
    import div_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              annul_i,
    output logic              stall_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              div_by_zero_o
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(BITS_PER_CYCLE);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] dvd_q;      // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] rem_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic              active;
    logic              load_ops;
    logic              step_en;
    logic              finish;
    logic              zero_done;
    logic [DATA_W-1:0] rem_last;
    logic [DATA_W-1:0] dvd_last;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                  input logic is_signed);
        logic signed [DATA_W-1:0] xs;
        xs = x;
        // -2^(DATA_W-1) maps onto itself, which is its correct unsigned magnitude.
        return (is_signed && xs < 0) ? DATA_W'(-xs) : x;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] x,
                                                     input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // Step chain: BITS_PER_CYCLE restoring steps per clock.
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        logic [DATA_W-1:0] rem_in, dvd_in, rem_out, dvd_out;
        logic              q_bit;
        if (k == 0) begin : g_first
            assign rem_in = rem_q;
            assign dvd_in = dvd_q;
        end else begin : g_next
            assign rem_in = g_step[k-1].rem_out;
            assign dvd_in = g_step[k-1].dvd_out;
        end
        div_step #(.DATA_W(DATA_W)) u_step (
            .rem_i     (rem_in),
            .divisor_i (dvs_q),
            .bit_i     (dvd_in[DATA_W-1]),
            .rem_o     (rem_out),
            .q_o       (q_bit)
        );
        assign dvd_out = {dvd_in[DATA_W-2:0], q_bit};
    end

    assign rem_last = g_step[BITS_PER_CYCLE-1].rem_out;
    assign dvd_last = g_step[BITS_PER_CYCLE-1].dvd_out;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DivFree;
        else     state_q <= state_d;
    end

    // Next-state logic; annul_i or a dropped request always returns to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree:   if (active) state_d = (divisor_i == '0) ? DivByZero : DivOn;
            DivOn:     if (!active)    state_d = DivFree;
                       else if (finish) state_d = DivEnd;
            DivByZero: state_d = active ? DivEnd : DivFree;
            DivEnd:    state_d = active ? DivEnd : DivFree;
            default:   state_d = DivFree;
        endcase
    end

    // Control outputs
    always_comb begin
        active    = (start_i == DivStart) && !annul_i;
        load_ops  = (state_q == DivFree) && active;
        step_en   = (state_q == DivOn) && active;
        finish    = step_en && (cnt_q == CNT_LAST);
        zero_done = (state_q == DivByZero) && active;
        stall_o   = start_i && !ready_o && !annul_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_q <= '0;
        else if (load_ops) cnt_q <= '0;
        else if (step_en)  cnt_q <= cnt_q + CNT_INC;
    end

    // Working operands: reloaded in full on every accept, so an aborted
    // divide leaves nothing behind for the next one.
    always_ff @(posedge clk) begin
        if (load_ops) begin
            dvd_q     <= abs_val(dividend_i, signed_i);
            dvs_q     <= abs_val(divisor_i, signed_i);
            rem_q     <= '0;
            neg_quo_q <= signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            neg_rem_q <= signed_i && dividend_i[DATA_W-1];
        end else if (step_en) begin
            dvd_q <= dvd_last;
            rem_q <= rem_last;
        end
    end

    // Results; ready_o trails entry into END by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_o       <= DivResultNotReady;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            ready_o <= ((state_q == DivEnd) && active) ? DivResultReady : DivResultNotReady;
            if (finish) begin
                quotient_o  <= apply_sign(dvd_last, neg_quo_q);
                remainder_o <= apply_sign(rem_last, neg_rem_q);
            end
            if (zero_done) begin
                quotient_o    <= '0;
                remainder_o   <= '0;
                div_by_zero_o <= 1'b1;
            end else if (state_d == DivFree) begin
                div_by_zero_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;

    logic        clk, rst, start, sgn, annul;
    logic [31:0] dividend, divisor;
    logic        stall1, ready1, dz1, stall2, ready2, dz2;
    logic [31:0] q1, r1, q2, r2;

    int tests = 0;
    int fails = 0;

    hilo_div_unit #(.DATA_W(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
        .dividend_i(dividend), .divisor_i(divisor), .annul_i(annul),
        .stall_o(stall1), .ready_o(ready1), .quotient_o(q1),
        .remainder_o(r1), .div_by_zero_o(dz1)
    );

    hilo_div_unit #(.DATA_W(32), .BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
        .dividend_i(dividend), .divisor_i(divisor), .annul_i(annul),
        .stall_o(stall2), .ready_o(ready2), .quotient_o(q2),
        .remainder_o(r2), .div_by_zero_o(dz2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Reference: language-level integer division (truncating, remainder
    // takes the dividend's sign), done in 64 bits and wrapped to 32.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic s, output logic [31:0] q,
                                    output logic [31:0] r, output logic dz);
        longint sa, sb;
        dz = (b == 0);
        q  = 0;
        r  = 0;
        if (b != 0) begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = 32'(sa / sb);
                r  = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Called at a negedge; the next posedge is the accepting edge 0.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input string name);
        int lat1, lat2, stall_cnt, exp1, exp2;
        exp1 = edz ? 2 : 33;
        exp2 = edz ? 2 : 17;
        dividend = a; divisor = b; sgn = s; start = 1; annul = 0;
        lat1 = -1; lat2 = -1; stall_cnt = 0;
        for (int n = 0; n < 80 && lat1 < 0; n++) begin
            @(negedge clk);
            if (ready2 && lat2 < 0) lat2 = n;
            if (ready1) lat1 = n;
            else if (stall1) stall_cnt++;
        end
        // operands change after acceptance must not matter
        check({name, " lat1"}, lat1, exp1);
        check({name, " lat2"}, lat2, exp2);
        check({name, " stallcnt"}, stall_cnt, exp1);
        check({name, " stall_at_ready"}, {31'b0, stall1}, 0);
        check({name, " q1"}, q1, eq);
        check({name, " r1"}, r1, er);
        check({name, " dz1"}, {31'b0, dz1}, {31'b0, edz});
        check({name, " q2"}, q2, eq);
        check({name, " r2"}, r2, er);
        check({name, " dz2"}, {31'b0, dz2}, {31'b0, edz});
        start = 0;
        dividend = $urandom; divisor = $urandom;
        @(negedge clk);
        check({name, " ready_cleared"}, {30'b0, ready1, ready2}, 0);
        check({name, " dz_cleared"}, {30'b0, dz1, dz2}, 0);
        check({name, " q1_kept"}, q1, eq);
    endtask

    task automatic watch_no_ready(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (ready1 || ready2) seen++;
        end
        check({name, " no_ready"}, seen, 0);
    endtask

    initial begin
        logic [31:0] a, b, eq, er;
        logic        s, edz;

        vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        vecs[2] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0};
        vecs[3] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0};
        vecs[4] = '{32'd5,         32'd0,         1'b0, 32'd0,         32'd0,         1'b1};
        vecs[5] = '{32'hFFFFFFFF,  32'd3,         1'b0, 32'h55555555,  32'd0,         1'b0};
        vecs[6] = '{32'd1000,      32'd10,        1'b0, 32'd100,       32'd0,         1'b0};
        vecs[7] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'd1,         32'd0,         1'b0};
        vecs[8] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0};
        vecs[9] = '{32'd7,         32'd0,         1'b1, 32'd0,         32'd0,         1'b1};

        rst = 1; start = 0; sgn = 0; annul = 0; dividend = 0; divisor = 0;
        #1;
        check("reset ready", {30'b0, ready1, ready2}, 0);
        check("reset q", q1 | q2, 0);
        check("reset r", r1 | r2, 0);
        check("reset dz", {30'b0, dz1, dz2}, 0);
        check("reset stall_idle", {30'b0, stall1, stall2}, 0);
        start = 1;
        #1;
        check("reset stall_follows_start", {30'b0, stall1, stall2}, 32'd3);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].dz,
                    $sformatf("vec%0d", i));

        // Annul at cycle 10, then an immediate 1000/10.
        dividend = 32'd123456; divisor = 32'd789; sgn = 0; start = 1;
        watch_no_ready(10, "annul_pre");
        annul = 1;
        dividend = 32'd1000; divisor = 32'd10;
        #1;
        check("annul stall", {30'b0, stall1, stall2}, 0);
        watch_no_ready(1, "annul_edge");
        run_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, "after_annul");

        // Asynchronous reset in the middle of ON; q1 holds 100 beforehand.
        dividend = 32'd99999; divisor = 32'd7; sgn = 0; start = 1;
        repeat (12) @(negedge clk);
        #2 rst = 1;
        #1;
        check("midrst ready", {30'b0, ready1, ready2}, 0);
        check("midrst q", q1 | q2, 0);
        check("midrst r", r1 | r2, 0);
        check("midrst dz", {30'b0, dz1, dz2}, 0);
        start = 0;
        @(negedge clk);
        rst = 0;
        watch_no_ready(3, "midrst_release");
        run_div(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, "after_rst");

        // Request dropped at cycle 5.
        dividend = 32'd99; divisor = 32'd9; sgn = 0; start = 1;
        repeat (5) @(negedge clk);
        start = 0;
        watch_no_ready(40, "drop");
        run_div(32'hFFFFFFFF, 32'd3, 1'b0, 32'h55555555, 32'd0, 1'b0, "after_drop");

        // Random sweep against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 3 == 1) b = {{16{b[15]}}, b[15:0]};
            s = 1'($urandom_range(0, 1));
            if (i % 13 == 5) b = 0;
            if (i % 11 == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; s = 1; end
            ref_div(a, b, s, eq, er, edz);
            run_div(a, b, s, eq, er, edz, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
